// File: rtl/mul_pkg.sv
// Shared constants, types and helpers for the iterative multiplier.
package mul_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned TAG_W     = 5;
    localparam int unsigned MUL_STEPS = 32;
    localparam int unsigned CNT_W     = $clog2(MUL_STEPS);

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } mul_op_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY   = 3'd1,
        NEG_LO = 3'd2,
        NEG_HI = 3'd3,
        DONE   = 3'd4
    } mul_state_e;

    // Magnitude of a two's-complement operand; 0x80000000 maps to itself (read unsigned).
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic is_neg);
        return is_neg ? (~x + XLEN'(1)) : x;
    endfunction

endpackage

// File: rtl/carry_lookahead_adder.sv
// W-bit adder built from 4-bit carry-lookahead groups with group carries chained.
// Ports: i_a, i_b operands; i_cin carry in; o_sum sum; o_cout carry out.
module carry_lookahead_adder #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);

    localparam int unsigned GRP  = 4;
    localparam int unsigned NGRP = W / GRP;

    logic [W-1:0]  w_g;
    logic [W-1:0]  w_p;
    logic [NGRP:0] w_cg;
    logic [GRP:0]  w_grp_c [NGRP];

    // Flattened lookahead equations for one 4-bit group: returns {c4,c3,c2,c1,c0}.
    function automatic logic [GRP:0] cla4(input logic [GRP-1:0] g, input logic [GRP-1:0] p,
                                          input logic ci);
        logic [GRP:0] c;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

    assign w_g     = i_a & i_b;
    assign w_p     = i_a ^ i_b;
    assign w_cg[0] = i_cin;

    for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
        assign w_grp_c[gi]           = cla4(w_g[gi*GRP +: GRP], w_p[gi*GRP +: GRP], w_cg[gi]);
        assign w_cg[gi+1]            = w_grp_c[gi][GRP];
        assign o_sum[gi*GRP +: GRP]  = w_p[gi*GRP +: GRP] ^ w_grp_c[gi][GRP-1:0];
    end

    assign o_cout = w_cg[NGRP];

endmodule

// File: rtl/iterative_multiplier.sv
// Multi-cycle 32x32->64 shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// One partial-product add per cycle through a shared 32-bit CLA, then an optional
// two-cycle negate of the 64-bit product when the signed result is negative.
// Ports:
//   clock, reset           rising-edge clock, async active-high reset
//   in_valid/in_ready      request handshake; in_op, in_a, in_b, in_tag request payload
//   kill                   synchronous abort of any in-flight or pending op
//   out_valid/out_ready    result handshake; out_result, out_tag registered result
module iterative_multiplier
    import mul_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             kill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    mul_state_e       r_state, w_state_nxt;
    mul_op_e          r_op, w_op_nxt;
    logic [TAG_W-1:0] r_tag, w_tag_nxt;
    logic             r_neg, w_neg_nxt;
    logic [XLEN-1:0]  r_mcand, w_mcand_nxt;
    logic [XLEN-1:0]  r_acc_hi, w_acc_hi_nxt;
    logic [XLEN-1:0]  r_lo, w_lo_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_carry, w_carry_nxt;
    logic             r_in_ready, w_in_ready_nxt;
    logic             r_out_valid, w_out_valid_nxt;
    logic [XLEN-1:0]  r_out_result, w_out_result_nxt;
    logic [TAG_W-1:0] r_out_tag, w_out_tag_nxt;

    logic [XLEN-1:0]  w_add_a, w_add_b, w_add_sum;
    logic             w_add_cin, w_add_cout;

    mul_op_e          w_op_in;
    logic             w_a_neg, w_b_neg;
    logic             w_step_c;
    logic [XLEN-1:0]  w_step_s;
    logic [XLEN-1:0]  w_hi_step, w_lo_step;

    // Request decode: sign handling of each operand.
    assign w_op_in = mul_op_e'(in_op);
    assign w_a_neg = ((w_op_in == MULH) || (w_op_in == MULHSU)) && in_a[XLEN-1];
    assign w_b_neg = (w_op_in == MULH) && in_b[XLEN-1];

    // One shift-add step: add the multiplicand only when the current multiplier bit is set.
    assign {w_step_c, w_step_s} = r_lo[0] ? {w_add_cout, w_add_sum} : {1'b0, r_acc_hi};
    assign w_hi_step = {w_step_c, w_step_s[XLEN-1:1]};
    assign w_lo_step = {w_step_s[0], r_lo[XLEN-1:1]};

    // Adder operand mux, selected by state.
    always_comb begin
        w_add_a   = r_acc_hi;
        w_add_b   = r_mcand;
        w_add_cin = 1'b0;
        case (r_state)
            NEG_LO: begin
                w_add_a   = ~r_lo;
                w_add_b   = '0;
                w_add_cin = 1'b1;
            end
            NEG_HI: begin
                w_add_a   = ~r_acc_hi;
                w_add_b   = '0;
                w_add_cin = r_carry;
            end
            default: ;
        endcase
    end

    carry_lookahead_adder #(
        .W (XLEN)
    ) u_cla (
        .i_a    (w_add_a),
        .i_b    (w_add_b),
        .i_cin  (w_add_cin),
        .o_sum  (w_add_sum),
        .o_cout (w_add_cout)
    );

    // Next-state and datapath/output next values.
    always_comb begin
        w_state_nxt      = r_state;
        w_op_nxt         = r_op;
        w_tag_nxt        = r_tag;
        w_neg_nxt        = r_neg;
        w_mcand_nxt      = r_mcand;
        w_acc_hi_nxt     = r_acc_hi;
        w_lo_nxt         = r_lo;
        w_cnt_nxt        = r_cnt;
        w_carry_nxt      = r_carry;
        w_out_valid_nxt  = r_out_valid;
        w_out_result_nxt = r_out_result;
        w_out_tag_nxt    = r_out_tag;

        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_op_nxt     = w_op_in;
                    w_tag_nxt    = in_tag;
                    w_neg_nxt    = w_a_neg ^ w_b_neg;
                    w_mcand_nxt  = mag(in_a, w_a_neg);
                    w_acc_hi_nxt = '0;
                    w_lo_nxt     = mag(in_b, w_b_neg);
                    w_cnt_nxt    = '0;
                    w_state_nxt  = BUSY;
                end
            end
            BUSY: begin
                w_acc_hi_nxt = w_hi_step;
                w_lo_nxt     = w_lo_step;
                w_cnt_nxt    = CNT_W'(r_cnt + CNT_W'(1));
                if (r_cnt == CNT_W'(MUL_STEPS - 1)) begin
                    if (r_neg) begin
                        w_state_nxt = NEG_LO;
                    end else begin
                        w_state_nxt      = DONE;
                        w_out_valid_nxt  = 1'b1;
                        w_out_result_nxt = (r_op == MUL) ? w_lo_step : w_hi_step;
                        w_out_tag_nxt    = r_tag;
                    end
                end
            end
            NEG_LO: begin
                w_lo_nxt    = w_add_sum;
                w_carry_nxt = w_add_cout;
                w_state_nxt = NEG_HI;
            end
            NEG_HI: begin
                w_acc_hi_nxt     = w_add_sum;
                w_state_nxt      = DONE;
                w_out_valid_nxt  = 1'b1;
                w_out_result_nxt = (r_op == MUL) ? r_lo : w_add_sum;
                w_out_tag_nxt    = r_tag;
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt     = IDLE;
                    w_out_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt     = IDLE;
                w_out_valid_nxt = 1'b0;
            end
        endcase

        // Flush wins over any accept or result handshake in the same cycle.
        if (kill) begin
            w_state_nxt     = IDLE;
            w_out_valid_nxt = 1'b0;
        end

        w_in_ready_nxt = (w_state_nxt == IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_op         <= MUL;
            r_tag        <= '0;
            r_neg        <= 1'b0;
            r_mcand      <= '0;
            r_acc_hi     <= '0;
            r_lo         <= '0;
            r_cnt        <= '0;
            r_carry      <= 1'b0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_tag    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_op         <= w_op_nxt;
            r_tag        <= w_tag_nxt;
            r_neg        <= w_neg_nxt;
            r_mcand      <= w_mcand_nxt;
            r_acc_hi     <= w_acc_hi_nxt;
            r_lo         <= w_lo_nxt;
            r_cnt        <= w_cnt_nxt;
            r_carry      <= w_carry_nxt;
            r_in_ready   <= w_in_ready_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_out_result <= w_out_result_nxt;
            r_out_tag    <= w_out_tag_nxt;
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_tag    = r_out_tag;

endmodule

// File: tb/tb_iterative_multiplier.sv
// Scoreboard bench for iterative_multiplier: directed ops push expected results,
// a negedge monitor pops and checks result, tag and latency on each new output.
module tb_iterative_multiplier;
    import mul_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_tag;
    logic        kill;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_tag;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   seen     = 1'b0;

    iterative_multiplier dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .kill       (kill),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Issue one request; record the accept edge and push the expectation if a result is due.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic [31:0] res, input int lat,
                         input bit want);
        int   waited = 0;
        bit   got    = 1'b0;
        exp_t e;
        @(posedge clock); #1;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
        while (!got && waited < 200) begin
            @(negedge clock);
            if (in_ready) begin
                @(posedge clock); #1;
                got = 1'b1;
            end else begin
                waited++;
            end
        end
        in_valid = 1'b0;
        if (!got) begin
            checks++; failures++;
            $display("FAIL accept_timeout tag=%0d", tag);
        end else if (want) begin
            e.res = res; e.tag = tag; e.lat = lat; e.acc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (n >= 300) begin
            checks++; failures++;
            $display("FAIL drain_timeout pending=%0d", sb.size());
        end
    endtask

    // Monitor: check each newly presented result exactly once.
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            seen = 1'b0;
        end else if (out_valid) begin
            if (!seen) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_output actual=0x%08h required=none", out_result);
                end else begin
                    e = sb.pop_front();
                    chk("result", out_result, e.res);
                    chk("tag", 32'(out_tag), 32'(e.tag));
                    chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                end
            end
            if (out_ready) seen = 1'b0;
        end else begin
            seen = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; in_valid = 1'b0; in_op = 2'd0; in_a = '0; in_b = '0; in_tag = '0;
        kill = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", out_result, 32'h0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        reset = 1'b0;

        // Basic and boundary products.
        do_op(MUL,    32'd7,        32'd6,        5'd3,  32'h0000002A, 33, 1'b1);
        do_op(MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'h00000000, 33, 1'b1);
        do_op(MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'h00000001, 33, 1'b1);
        do_op(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, 33, 1'b1);
        do_op(MULH,   32'h80000000, 32'h80000000, 5'd7,  32'h40000000, 33, 1'b1);
        do_op(MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF, 35, 1'b1);
        do_op(MULHSU, 32'h80000000, 32'h00000002, 5'd9,  32'hFFFFFFFF, 35, 1'b1);
        do_op(MULH,   32'h7FFFFFFF, 32'h7FFFFFFF, 5'd10, 32'h3FFFFFFF, 33, 1'b1);
        do_op(MULHU,  32'h00000000, 32'h12345678, 5'd11, 32'h00000000, 33, 1'b1);
        do_op(MUL,    32'hFFFFFFF9, 32'h00000006, 5'd12, 32'hFFFFFFD6, 33, 1'b1);
        drain();

        // Back-pressure in DONE: outputs hold, no new request accepted.
        out_ready = 1'b0;
        do_op(MUL, 32'h0000FFFF, 32'h00010001, 5'd13, 32'hFFFFFFFF, 33, 1'b1);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!out_valid && n < 100);
        chk("bp_valid_seen", 32'(out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_result", out_result, 32'hFFFFFFFF);
            chk("bp_tag", 32'(out_tag), 32'd13);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clock); #1;
        out_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("hs_in_ready", 32'(in_ready), 32'd1);
        chk("hs_out_valid", 32'(out_valid), 32'd0);

        // Kill mid-BUSY drops the op.
        do_op(MULHU, 32'd5, 32'd5, 5'd14, 32'h0, 0, 1'b0);
        repeat (11) @(posedge clock);
        #1 kill = 1'b1;
        @(posedge clock);
        #1 kill = 1'b0;
        @(negedge clock);
        chk("kill_in_ready", 32'(in_ready), 32'd1);
        chk("kill_out_valid", 32'(out_valid), 32'd0);

        // Kill beats a simultaneous accept.
        @(posedge clock); #1;
        in_valid = 1'b1; in_op = MUL; in_a = 32'd3; in_b = 32'd3; in_tag = 5'd15; kill = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0; kill = 1'b0;
        @(negedge clock);
        chk("kill_accept_in_ready", 32'(in_ready), 32'd1);

        // Async reset mid-BUSY.
        do_op(MULH, 32'd9, 32'd9, 5'd16, 32'h0, 0, 1'b0);
        repeat (15) @(posedge clock);
        #1 reset = 1'b1;
        #2;
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_result", out_result, 32'h0);
        chk("arst_out_tag", 32'(out_tag), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;

        // Recovery with a negated result whose low half produces no carry.
        do_op(MULH, 32'h7FFFFFFF, 32'h80000000, 5'd17, 32'hC0000000, 35, 1'b1);
        do_op(MUL,  32'h7FFFFFFF, 32'h80000000, 5'd18, 32'h80000000, 33, 1'b1);
        drain();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
